// File: rtl/baud_pkg.sv
// Shared constants, state encoding and helpers for the baud-rate controller.
package baud_pkg;

    localparam int unsigned DIV_W          = 20;
    localparam int unsigned MODE_W         = 4;
    localparam int unsigned BAUD_MODE_MAX  = 11;
    localparam int unsigned BAUD_MODE_9600 = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // True when the mode code maps to a real divisor.
    function automatic logic mode_ok(input logic [MODE_W-1:0] m);
        return m <= MODE_W'(BAUD_MODE_MAX);
    endfunction

endpackage

// File: rtl/baud_ctrl_if.sv
// Configuration handshake and bit-timing strobes between UART datapath and baud_ctrl.
interface baud_ctrl_if;
    import baud_pkg::*;

    logic              en;
    logic              cfg_valid;
    logic [MODE_W-1:0] cfg_mode;
    logic              cfg_ready;
    logic              cfg_err;
    logic              phase_rst;
    logic [MODE_W-1:0] cur_mode;
    logic              tick;
    logic              half_tick;

    modport master (
        output en, cfg_valid, cfg_mode, phase_rst,
        input  cfg_ready, cfg_err, cur_mode, tick, half_tick
    );

    modport slave (
        input  en, cfg_valid, cfg_mode, phase_rst,
        output cfg_ready, cfg_err, cur_mode, tick, half_tick
    );

endinterface

// File: rtl/baud_dec.sv
// Mode code to clk-cycles-per-bit divisor at 100 MHz (300 .. 921600 baud).
module baud_dec
    import baud_pkg::*;
(
    input  logic [MODE_W-1:0] mode,
    output logic [DIV_W-1:0]  baud_rate
);

    // Combinational lookup; unused codes fall back to 9600 baud.
    always_comb begin
        baud_rate = 20'd10417;
        unique case (mode)
            4'd0:    baud_rate = 20'd333333;
            4'd1:    baud_rate = 20'd83333;
            4'd2:    baud_rate = 20'd41667;
            4'd3:    baud_rate = 20'd20833;
            4'd4:    baud_rate = 20'd10417;
            4'd5:    baud_rate = 20'd5208;
            4'd6:    baud_rate = 20'd2604;
            4'd7:    baud_rate = 20'd1736;
            4'd8:    baud_rate = 20'd868;
            4'd9:    baud_rate = 20'd434;
            4'd10:   baud_rate = 20'd217;
            4'd11:   baud_rate = 20'd109;
            default: baud_rate = 20'd10417;
        endcase
    end

endmodule

// File: rtl/baud_ctrl.sv
// Baud-rate controller: holds the active mode, defers mode changes to a bit
// boundary while running, and generates tick / half_tick strobes.
module baud_ctrl
    import baud_pkg::*;
#(
    parameter int unsigned RESET_MODE = BAUD_MODE_9600
) (
    input  logic       clk,
    input  logic       reset,
    baud_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [MODE_W-1:0] cur_mode_q, cur_mode_d;
    logic [MODE_W-1:0] pend_mode_q, pend_mode_d;
    logic              cfg_ready_q;
    logic              cfg_err_q;
    logic              tick_q;
    logic              half_tick_q;

    logic [DIV_W-1:0]  div;
    logic              running_c;
    logic              wrap_c;
    logic              tick_cond_c;
    logic              half_cond_c;
    logic              accept_c;
    logic              acc_ok_c;

    baud_dec u_dec (
        .mode      (cur_mode_q),
        .baud_rate (div)
    );

    // Strobe conditions and handshake decode from the current count and state.
    always_comb begin
        running_c   = (state_q != ST_IDLE);
        wrap_c      = (cnt_q == div - DIV_W'(1));
        tick_cond_c = running_c && !bus.phase_rst && wrap_c;
        half_cond_c = running_c && (cnt_q == (div >> 1) - DIV_W'(1));
        accept_c    = bus.cfg_valid && cfg_ready_q;
        acc_ok_c    = accept_c && mode_ok(bus.cfg_mode);
    end

    // Next state, counter and mode selection; en beats phase_rst beats mode switch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_mode_d  = cur_mode_q;
        pend_mode_d = pend_mode_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (acc_ok_c) cur_mode_d = bus.cfg_mode;
                if (bus.en)   state_d    = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = wrap_c ? '0 : cnt_q + DIV_W'(1);
                if (!bus.en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (acc_ok_c) cur_mode_d = bus.cfg_mode;
                end else begin
                    if (bus.phase_rst) cnt_d = '0;
                    if (acc_ok_c) begin
                        pend_mode_d = bus.cfg_mode;
                        state_d     = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                cnt_d = wrap_c ? '0 : cnt_q + DIV_W'(1);
                if (!bus.en) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    cur_mode_d = pend_mode_q;
                end else if (bus.phase_rst || tick_cond_c) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    cur_mode_d = pend_mode_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, mode registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cur_mode_q  <= MODE_W'(RESET_MODE);
            pend_mode_q <= MODE_W'(RESET_MODE);
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            tick_q      <= 1'b0;
            half_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_mode_q  <= cur_mode_d;
            pend_mode_q <= pend_mode_d;
            cfg_ready_q <= (state_d != ST_PEND);
            cfg_err_q   <= accept_c && !mode_ok(bus.cfg_mode);
            tick_q      <= tick_cond_c;
            half_tick_q <= half_cond_c;
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.cur_mode  = cur_mode_q;
    assign bus.tick      = tick_q;
    assign bus.half_tick = half_tick_q;

endmodule

// File: tb/tb_baud_ctrl.sv
// Self-checking bench for baud_ctrl: directed timing checks plus randomized
// traffic compared every cycle against an elapsed-time reference model.
module tb_baud_ctrl;

    logic clk = 1'b0;
    logic reset;

    baud_ctrl_if bus ();

    baud_ctrl #(.RESET_MODE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    int tick_q[$];
    int half_q[$];
    int err_n = 0;

    // Reference model state
    bit chk_en = 1'b0;
    bit m_run;
    bit m_pend;
    int m_mode;
    int m_pmode;
    int m_start;
    bit exp_tick, exp_half, exp_err, exp_ready;

    task automatic chk(input string nm, input int act, input int want);
        vecs++;
        if (act != want) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Bit period from the nominal baud rate at 100 MHz, rounded to nearest.
    function automatic int div_of(input int m);
        int rates [12] = '{300, 1200, 2400, 4800, 9600, 19200, 38400,
                           57600, 115200, 230400, 460800, 921600};
        if (m < 0 || m > 11) return 0;
        return (100_000_000 + rates[m] / 2) / rates[m];
    endfunction

    function automatic int tq(input int i);
        return (i < tick_q.size()) ? tick_q[i] : -100000;
    endfunction

    function automatic int hq(input int i);
        return (i < half_q.size()) ? half_q[i] : -100000;
    endfunction

    // Reference model: phase position from cycles elapsed since the phase began.
    always @(posedge clk) begin
        int  d, pos;
        bit  tc, hc, acc, good;
        cyc++;
        if (reset) begin
            chk_en    = 1'b1;
            m_run     = 1'b0;
            m_pend    = 1'b0;
            m_mode    = 4;
            m_pmode   = 4;
            m_start   = cyc;
            exp_tick  = 1'b0;
            exp_half  = 1'b0;
            exp_err   = 1'b0;
            exp_ready = 1'b1;
        end else if (chk_en) begin
            d    = div_of(m_mode);
            pos  = m_run ? (cyc - 1 - m_start) % d : -1;
            tc   = m_run && !bus.phase_rst && (pos == d - 1);
            hc   = m_run && (pos == d / 2 - 1);
            acc  = bus.cfg_valid && !m_pend;
            good = acc && (int'(bus.cfg_mode) <= 11);
            exp_err = acc && (int'(bus.cfg_mode) > 11);
            if (!m_run) begin
                if (good) m_mode = int'(bus.cfg_mode);
                if (bus.en) begin
                    m_run   = 1'b1;
                    m_start = cyc;
                end
            end else if (!bus.en) begin
                m_run = 1'b0;
                if (m_pend) begin
                    m_mode = m_pmode;
                    m_pend = 1'b0;
                end else if (good) begin
                    m_mode = int'(bus.cfg_mode);
                end
            end else if (bus.phase_rst) begin
                m_start = cyc;
                if (m_pend) begin
                    m_mode = m_pmode;
                    m_pend = 1'b0;
                end else if (good) begin
                    m_pend  = 1'b1;
                    m_pmode = int'(bus.cfg_mode);
                end
            end else if (tc && m_pend) begin
                m_mode  = m_pmode;
                m_pend  = 1'b0;
                m_start = cyc;
            end else if (good) begin
                m_pend  = 1'b1;
                m_pmode = int'(bus.cfg_mode);
            end
            exp_tick  = tc;
            exp_half  = hc;
            exp_ready = !m_pend;
        end
    end

    // Every-cycle comparison against the model, plus strobe event capture.
    always @(posedge clk) begin
        #1;
        if (bus.tick)      tick_q.push_back(cyc);
        if (bus.half_tick) half_q.push_back(cyc);
        if (bus.cfg_err)   err_n++;
        if (chk_en) begin
            chk("tick",      int'(bus.tick),      int'(exp_tick));
            chk("half_tick", int'(bus.half_tick), int'(exp_half));
            chk("cfg_ready", int'(bus.cfg_ready), int'(exp_ready));
            chk("cfg_err",   int'(bus.cfg_err),   int'(exp_err));
            chk("cur_mode",  int'(bus.cur_mode),  m_mode);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ticks(input int n, input int budget, input string nm);
        int b = budget;
        while (tick_q.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (tick_q.size() < n) begin
            vecs++;
            errs++;
            $display("FAIL %s: timeout, got %0d ticks expected %0d", nm, tick_q.size(), n);
        end
    endtask

    task automatic request(input int m);
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = 4'(m);
        cycles(1);
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, p;
        reset         = 1'b1;
        bus.en        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_mode  = 4'd0;
        bus.phase_rst = 1'b0;

        chk("model_div_m4",  div_of(4),  10417);
        chk("model_div_m10", div_of(10), 217);
        chk("model_div_m11", div_of(11), 109);

        // Reset and idle
        cycles(3);
        reset = 1'b0;
        cycles(20);
        chk("idle_cur_mode",  int'(bus.cur_mode),  4);
        chk("idle_cfg_ready", int'(bus.cfg_ready), 1);
        chk("idle_ticks",     tick_q.size() + half_q.size(), 0);
        chk("idle_errs",      err_n, 0);

        // IDLE mode change then enable
        request(11);
        chk("idle_mode_update", int'(bus.cur_mode), 11);
        tick_q.delete();
        half_q.delete();
        bus.en = 1'b1;
        k = cyc + 1;
        wait_ticks(3, 400, "first_ticks");
        chk("tick1", tq(0) - k, 109);
        chk("tick2", tq(1) - k, 218);
        chk("tick3", tq(2) - k, 327);
        chk("half1", hq(0) - k, 54);
        chk("half2", hq(1) - k, 163);

        // Deferred mode change in RUN
        cycles(30);
        tick_q.delete();
        request(10);
        chk("pend_not_ready", int'(bus.cfg_ready), 0);
        wait_ticks(1, 300, "switch_tick");
        chk("switch_cur_mode", int'(bus.cur_mode), 10);
        chk("switch_ready",    int'(bus.cfg_ready), 1);
        wait_ticks(2, 300, "post_switch_tick");
        chk("post_switch_period", tq(1) - tq(0), 217);

        // Out-of-range request in RUN
        cycles(20);
        err_n = 0;
        request(13);
        chk("err_pulse", int'(bus.cfg_err), 1);
        cycles(1);
        chk("err_cleared", int'(bus.cfg_err), 0);
        chk("err_count",   err_n, 1);
        chk("err_mode",    int'(bus.cur_mode), 10);
        chk("err_ready",   int'(bus.cfg_ready), 1);
        tick_q.delete();
        wait_ticks(2, 600, "err_period");
        chk("err_period", tq(1) - tq(0), 217);

        // phase_rst coincident with the wrap
        request(11);
        tick_q.delete();
        wait_ticks(2, 600, "m11_ticks");
        chk("m11_period", tq(1) - tq(0), 109);
        cycles(108);
        tick_q.delete();
        half_q.delete();
        bus.phase_rst = 1'b1;
        p = cyc + 1;
        cycles(1);
        bus.phase_rst = 1'b0;
        wait_ticks(1, 200, "phase_tick");
        chk("phase_tick", tq(0) - p, 109);
        chk("phase_half", hq(0) - p, 54);

        // Reset while a change is pending
        request(10);
        chk("pend2_not_ready", int'(bus.cfg_ready), 0);
        cycles(5);
        reset  = 1'b1;
        bus.en = 1'b0;
        cycles(1);
        reset = 1'b0;
        chk("rst_cur_mode", int'(bus.cur_mode),  4);
        chk("rst_ready",    int'(bus.cfg_ready), 1);
        chk("rst_strobes",  int'(bus.tick) + int'(bus.half_tick) + int'(bus.cfg_err), 0);
        cycles(5);
        chk("rst_discard", int'(bus.cur_mode), 4);

        // Randomized traffic
        request(11);
        bus.en = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (bus.en && $urandom_range(0, 299) == 0)       bus.en = 1'b0;
            else if (!bus.en && $urandom_range(0, 9) == 0)   bus.en = 1'b1;
            bus.cfg_valid = ($urandom_range(0, 39) == 0);
            bus.cfg_mode  = 4'($urandom_range(7, 15));
            bus.phase_rst = ($urandom_range(0, 149) == 0);
            reset         = ($urandom_range(0, 2999) == 0);
        end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        bus.phase_rst = 1'b0;
        reset         = 1'b0;
        cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/baud_ctrl.md
# baud_ctrl

Baud-rate controller that owns the `baud_dec` divisor lookup and sequences it for the UART datapath. It holds the active baud mode and accepts mode changes through a valid/ready handshake, deferring changes to a bit boundary while running. It generates the per-bit `tick` and mid-bit `half_tick` strobes consumed by the UART transmitter and receiver.

## Interface
- `RESET_MODE`, 4: mode loaded on reset (4 = 9600 baud).
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable; 0 holds the counter cleared.
- `cfg_valid`  in  1  mode-change request.
- `cfg_mode`  in  4  requested mode; valid range 0–11.
- `cfg_ready`  out  1  controller can accept a request this cycle.
- `cfg_err`  out  1  one-cycle pulse: a request with mode > 11 was rejected.
- `phase_rst`  in  1  restart bit phase (receiver start-bit edge).
- `cur_mode`  out  4  mode currently driving the divisor.
- `tick`  out  1  one-cycle pulse, once per bit period.
- `half_tick`  out  1  one-cycle pulse at mid-bit.

## Operation
- Divisor `div` (20 bits) is `baud_rate` from `baud_dec(cur_mode)`, in clk cycles per bit: mode 4 → 10417, mode 11 → 109. All valid divisors are ≥ 2.
- States: IDLE, RUN, PEND.
  - IDLE: `cnt` = 0; no strobes; `cfg_ready` = 1. An accepted valid request updates `cur_mode` at the next edge. If `en` = 1, go to RUN.
  - RUN: `cnt` increments each cycle and wraps to 0 after `div`−1. `cfg_ready` = 1. An accepted valid request is latched into `pend_mode` and the state goes to PEND.
  - PEND: counts as in RUN; `cfg_ready` = 0. On the cycle the tick condition holds, `cur_mode` ← `pend_mode`, `cnt` ← 0 and the state returns to RUN. The next period uses the new `div`.
- Handshake: a request is accepted when `cfg_valid & cfg_ready`.
- If an accepted request has `cfg_mode` > 11:
  - `cfg_err` pulses in the next cycle.
  - Mode, state and `pend_mode` are unchanged.
- `en` = 0 in RUN or PEND:
  - Next state is IDLE and `cnt` ← 0.
  - Any pending mode is applied to `cur_mode` at the same edge.
- `phase_rst` in RUN or PEND:
  - `cnt` ← 0 at the next edge.
  - `phase_rst` has priority over wrap, so the coincident tick is suppressed.
  - A pending mode is applied on this restart.
  - `phase_rst` is ignored in IDLE.
- `en` = 0 has priority over `phase_rst`, which has priority over a mode switch.
- Reset: state = IDLE, `cnt` = 0, `cur_mode` = `RESET_MODE`, `pend_mode` = `RESET_MODE`, `cfg_ready` = 1, `cfg_err` = 0, `tick` = 0, `half_tick` = 0. Reset overrides everything, and any pending mode is discarded.

## Timing
- All outputs are registered. `cfg_ready` is a registered decode of the state.
- Tick condition: `cnt == div-1` in RUN/PEND without `phase_rst`. `tick` is high in the cycle after the condition.
- `en` sampled high at edge k: the first `tick` is high in the cycle starting at edge k+`div`. Subsequent ticks have a period of exactly `div`.
- `half_tick` condition: `cnt == (div>>1)-1`. For mode 11 this is `cnt` = 53, so `half_tick` follows 54 cycles after the phase start.
- After `phase_rst` is sampled at edge p: `half_tick` at p+`(div>>1)`, `tick` at p+`div`.
- IDLE mode change: `cur_mode` updates one edge after acceptance.
- `cfg_err` latency: one cycle after acceptance.

## Structure
- Shared package `baud_pkg`:
  - Mode constants `BAUD_MODE_MAX` = 11 and `BAUD_MODE_9600` = 4.
  - Divisor width 20.
  - State encoding IDLE/RUN/PEND.
- One sub-module: the existing `baud_dec`, instantiated combinationally on `cur_mode`.
- Counter, FSM and handshake logic stay in `baud_ctrl`.

## Test plan
- Reset, then `en` held 0 for 20 cycles → `cur_mode` = 4, `cfg_ready` = 1, no `tick`, `half_tick` or `cfg_err`.
- IDLE, request mode 11, then `en` = 1 at edge k → `tick` at k+109, k+218, k+327; `half_tick` at k+54, k+163.
- Mode 11 running, request mode 10 mid-period → `cfg_ready` = 0 until the next `tick`. `cur_mode` becomes 10 at that tick, and the following tick is 217 cycles later.
- Request mode 13 in RUN → `cfg_err` pulses once. `cur_mode` and the tick period are unchanged, and the state stays RUN.
- Mode 11, `phase_rst` on the cycle where `cnt` = 108 → no `tick` that period; next `tick` 109 cycles after `phase_rst`, `half_tick` 54 cycles after.
- Assert `reset` while in PEND with mode 10 pending → next cycle: IDLE, `cur_mode` = 4, pending mode discarded, all strobes 0.
